phase_accumulator: RTL and testbench

Numerically controlled phase generator that produces the table address driving the waveform stage (saw_tooth and sibling tables) in the synth voice.
- Divides the system clock down to the audio sample rate.
- Accumulates a frequency tuning word once per sample.
- Presents the top ADDR_WIDTH bits of phase as addr_r.
- Supports glitch-free frequency updates, hard sync, and a wrap pulse for downstream/sync chaining.

---
 rtl/synth_pkg.sv | 17 +
 rtl/sample_tick_gen.sv | 38 +++
 rtl/phase_accumulator.sv | 147 ++++++++++++++
 tb/tb_phase_accumulator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared synth-voice definitions: clock/sample-rate constants, default
// datapath widths and the phase / table-address types.
package synth_pkg;

  localparam int unsigned SYS_CLK_HZ = 100_000_000;
  localparam int unsigned SAMPLE_HZ  = 44_100;

  localparam int unsigned ACC_WIDTH  = 24;
  localparam int unsigned ADDR_WIDTH = 8;

  // Rounded clk cycles per audio sample (2268 at 100 MHz / 44.1 kHz).
  localparam int unsigned TICK_DIV_DFLT = (SYS_CLK_HZ + SAMPLE_HZ / 2) / SAMPLE_HZ;

  typedef logic [ACC_WIDTH-1:0]  phase_t;
  typedef logic [ADDR_WIDTH-1:0] tbl_addr_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator: divides clk by TICK_DIV while en is high.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset (counter to 0)
//   en    - count enable; low holds the counter and suppresses tick
//   tick  - combinational, high in the last cycle of each TICK_DIV period
module sample_tick_gen
  import synth_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Modulo-TICK_DIV counter, frozen when disabled.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign tick = en && (count_q == LAST);

endmodule

// File: rtl/phase_accumulator.sv
// NCO phase accumulator producing the waveform table address for a voice.
// Optional macro PHASE_ACC_GLIDE_EN: adds glide_step and slews the active
// tuning word toward the last written word instead of switching at once.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   en          - run enable (freezes tick counter and phase when low)
//   freq_wr     - strobe capturing freq_in as the next tuning word
//   freq_in     - tuning word (phase increment per sample)
//   sync        - hard sync: zero phase at the next sample tick
//   glide_step  - (glide build only) max tuning-word change per tick
//   addr_r      - top ADDR_WIDTH bits of the phase accumulator
//   sample_tick - one-cycle pulse in the cycle whose edge updates phase
//   wrap        - registered pulse when the phase add carries out
//   freq_busy   - a written tuning word is not yet fully active
module phase_accumulator
  import synth_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = synth_pkg::ACC_WIDTH,
  parameter int unsigned ADDR_WIDTH = synth_pkg::ADDR_WIDTH,
  parameter int unsigned TICK_DIV   = TICK_DIV_DFLT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  freq_wr,
  input  logic [ACC_WIDTH-1:0]  freq_in,
  input  logic                  sync,
`ifdef PHASE_ACC_GLIDE_EN
  input  logic [ACC_WIDTH-1:0]  glide_step,
`endif
  output logic [ADDR_WIDTH-1:0] addr_r,
  output logic                  sample_tick,
  output logic                  wrap,
  output logic                  freq_busy
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] active_q, active_d;
  logic                 sync_pending_q, sync_pending_d;
  logic                 wrap_q, wrap_d;
  logic                 freq_busy_q, freq_busy_d;
  logic [ACC_WIDTH:0]   sum;

`ifdef PHASE_ACC_GLIDE_EN
  logic [ACC_WIDTH-1:0] target_q, target_d;
  logic [ACC_WIDTH-1:0] gap, step;
  logic                 rising;
`else
  logic [ACC_WIDTH-1:0] pending_q, pending_d;
  logic                 pending_valid_q, pending_valid_d;
`endif

  sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (sample_tick)
  );

  // Phase add with carry; uses the tuning word active before this tick.
  assign sum = {1'b0, acc_q} + {1'b0, active_q};

`ifdef PHASE_ACC_GLIDE_EN
  // Distance and direction to the target; zero step means jump straight there.
  assign rising = (target_q >= active_q);
  assign gap    = rising ? (target_q - active_q) : (active_q - target_q);
  assign step   = ((glide_step == '0) || (glide_step >= gap)) ? gap : glide_step;
`endif

  always_comb begin
    acc_d          = acc_q;
    active_d       = active_q;
    sync_pending_d = sync_pending_q;
    wrap_d         = 1'b0;
`ifdef PHASE_ACC_GLIDE_EN
    target_d       = freq_wr ? freq_in : target_q;
`else
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
`endif

    if (sample_tick) begin
      // Sync beats the add; a consumed sync clears its pending flag.
      if (sync_pending_q || sync) begin
        acc_d  = '0;
        wrap_d = 1'b0;
      end else begin
        acc_d  = sum[ACC_WIDTH-1:0];
        wrap_d = sum[ACC_WIDTH];
      end
      sync_pending_d = 1'b0;
`ifdef PHASE_ACC_GLIDE_EN
      active_d = rising ? (active_q + step) : (active_q - step);
`else
      active_d        = freq_wr ? freq_in : (pending_valid_q ? pending_q : active_q);
      pending_valid_d = 1'b0;
`endif
    end else begin
      if (sync) sync_pending_d = 1'b1;
`ifndef PHASE_ACC_GLIDE_EN
      if (freq_wr) begin
        pending_d       = freq_in;
        pending_valid_d = 1'b1;
      end
`endif
    end

`ifdef PHASE_ACC_GLIDE_EN
    freq_busy_d = (active_d != target_d);
`else
    freq_busy_d = pending_valid_d;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q          <= '0;
      active_q       <= '0;
      sync_pending_q <= 1'b0;
      wrap_q         <= 1'b0;
      freq_busy_q    <= 1'b0;
`ifdef PHASE_ACC_GLIDE_EN
      target_q       <= '0;
`else
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
`endif
    end else begin
      acc_q          <= acc_d;
      active_q       <= active_d;
      sync_pending_q <= sync_pending_d;
      wrap_q         <= wrap_d;
      freq_busy_q    <= freq_busy_d;
`ifdef PHASE_ACC_GLIDE_EN
      target_q       <= target_d;
`else
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
`endif
    end
  end

  assign addr_r    = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH];
  assign wrap      = wrap_q;
  assign freq_busy = freq_busy_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator with TICK_DIV=4.
module tb_phase_accumulator;
  import synth_pkg::*;

  localparam int unsigned TD   = 4;
  localparam longint      MODV = 64'd1 << 24;

  logic      clk, reset, en, freq_wr, sync;
  phase_t    freq_in;
  tbl_addr_t addr_r;
  logic      sample_tick, wrap, freq_busy;
`ifdef PHASE_ACC_GLIDE_EN
  phase_t    glide_step;
  assign glide_step = '0;
`endif

  phase_accumulator #(.ACC_WIDTH(24), .ADDR_WIDTH(8), .TICK_DIV(TD)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .freq_wr     (freq_wr),
    .freq_in     (freq_in),
    .sync        (sync),
`ifdef PHASE_ACC_GLIDE_EN
    .glide_step  (glide_step),
`endif
    .addr_r      (addr_r),
    .sample_tick (sample_tick),
    .wrap        (wrap),
    .freq_busy   (freq_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: phase as an integer modulo 2^24.
  longint m_acc, m_active, m_pend;
  bit     m_pv, m_sync, m_wrap;
  int     m_cnt;
  logic   last_tick, last_wrap;

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_active = 0; m_pend = 0;
    m_pv = 0; m_sync = 0; m_wrap = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit e, input bit fw, input longint fin,
                            input bit sy, input bit tk);
    longint nxt, s;
    if (tk) begin
      nxt = fw ? fin : (m_pv ? m_pend : m_active);
      if (m_sync || sy) begin
        m_acc = 0; m_wrap = 0;
      end else begin
        s = m_acc + m_active;
        m_wrap = (s >= MODV);
        m_acc = s % MODV;
      end
      m_active = nxt; m_pv = 0; m_sync = 0;
    end else begin
      m_wrap = 0;
      if (fw) begin m_pend = fin; m_pv = 1; end
      if (sy) m_sync = 1;
    end
    if (e) m_cnt = (m_cnt + 1) % TD;
  endtask

  // One clock cycle: drive after negedge, check tick, clock, check registers.
  task automatic step(input logic e, input logic fw, input logic [23:0] fin,
                      input logic sy);
    logic exp_tick;
    en = e; freq_wr = fw; freq_in = fin; sync = sy;
    exp_tick = e && (m_cnt == TD - 1);
    #1;
    check("sample_tick", longint'(sample_tick), longint'(exp_tick));
    last_tick = sample_tick;
    @(posedge clk);
    model_edge(e, fw, longint'(fin), sy, exp_tick);
    #1;
    check("addr_r", longint'(addr_r), m_acc >> 16);
    check("wrap", longint'(wrap), longint'(m_wrap));
    check("freq_busy", longint'(freq_busy), longint'(m_pv));
    last_wrap = wrap;
    @(negedge clk);
    freq_wr = 1'b0; sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 24'h0, 1'b0);
  endtask

  typedef struct {
    logic        en;
    logic        fw;
    logic [23:0] fin;
    logic        sy;
    logic        x_tick;
    logic [7:0]  x_addr;
    logic        x_wrap;
    logic        x_busy;
  } vec_t;

  vec_t vecs [12];
  int   wraps;
  logic [7:0] a0;

  initial begin
    reset = 1'b1; en = 1'b0; freq_wr = 1'b0; freq_in = '0; sync = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst addr_r", longint'(addr_r), 0);
    check("rst wrap", longint'(wrap), 0);
    check("rst freq_busy", longint'(freq_busy), 0);
    check("rst sample_tick", longint'(sample_tick), 0);
    reset = 1'b0;

    // First word becomes active on the first tick; addr steps once per tick.
    for (int i = 0; i < 12; i++) begin
      vecs[i] = '{en: 1'b1, fw: (i == 0), fin: 24'h010000, sy: 1'b0,
                  x_tick: (i % 4 == 3), x_addr: 8'((i + 1) / 4 > 0 ? ((i + 1) / 4) - 1 : 0),
                  x_wrap: 1'b0, x_busy: (i < 3)};
    end
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].en, vecs[i].fw, vecs[i].fin, vecs[i].sy);
      check("tbl tick", longint'(last_tick), longint'(vecs[i].x_tick));
      check("tbl addr", longint'(addr_r), longint'(vecs[i].x_addr));
      check("tbl wrap", longint'(wrap), longint'(vecs[i].x_wrap));
      check("tbl busy", longint'(freq_busy), longint'(vecs[i].x_busy));
    end

    // addr is 0x02; 254 more steps reach 0x00 with exactly one wrap.
    wraps = 0;
    for (int i = 0; i < 254 * TD; i++) begin
      idle(1);
      if (last_wrap) wraps++;
    end
    check("wrap256 count", longint'(wraps), 1);
    check("wrap256 addr", longint'(addr_r), 0);

    // Frequency change one cycle after a tick: old word used for that tick.
    step(1'b1, 1'b1, 24'h020000, 1'b0);
    check("busy after wr", longint'(freq_busy), 1);
    idle(3);
    check("chg addr+1", longint'(addr_r), 8'h01);
    check("busy cleared", longint'(freq_busy), 0);
    idle(4);
    check("chg addr+2", longint'(addr_r), 8'h03);

    // Hard sync: reach addr 0x37 then sync two cycles before a tick.
    step(1'b1, 1'b1, 24'h370000, 1'b1);
    idle(3);
    check("sync zero", longint'(addr_r), 0);
    step(1'b1, 1'b1, 24'h010000, 1'b0);
    idle(3);
    check("addr 0x37", longint'(addr_r), 8'h37);
    idle(1);
    step(1'b1, 1'b0, 24'h0, 1'b1);
    idle(2);
    check("sync tick addr", longint'(addr_r), 0);
    check("sync tick wrap", longint'(wrap), 0);
    idle(4);
    check("post sync addr", longint'(addr_r), 8'h01);

    // Half-scale word: addr toggles by 0x80, wrap on every second tick.
    step(1'b1, 1'b1, 24'h800000, 1'b0);
    idle(3);
    a0 = addr_r;
    wraps = 0;
    for (int t = 0; t < 8; t++) begin
      idle(TD);
      if (last_wrap) wraps++;
      check("half toggle", longint'(addr_r ^ a0), (t % 2 == 0) ? 8'h80 : 8'h00);
    end
    check("half wraps", longint'(wraps), 4);

    // Disabled window: no ticks, phase frozen, write still captured.
    idle(1);
    a0 = addr_r;
    for (int i = 0; i < 10; i++) step(1'b0, (i == 4), 24'h010000, 1'b0);
    check("en0 frozen", longint'(addr_r), longint'(a0));
    check("en0 busy", longint'(freq_busy), 1);
    idle(TD);
    check("en1 busy clr", longint'(freq_busy), 0);
    idle(2);

    // Asynchronous reset mid-period.
    #2 reset = 1'b1;
    #1;
    check("async addr", longint'(addr_r), 0);
    check("async wrap", longint'(wrap), 0);
    check("async busy", longint'(freq_busy), 0);
    check("async tick", longint'(sample_tick), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(TD - 1);
    step(1'b1, 1'b0, 24'h0, 1'b0);
    check("restart tick", longint'(last_tick), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
           24'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
